// File: rtl/fpga_sync_handshake_rx.sv
// rtl/fpga_sync_handshake_rx.sv - destination-side responder of a four-phase req/ack CDC handshake
//
// Purpose:
//   Synchronises the source's level request into dest_clk, captures the
//   source's data bus (held stable by the protocol), presents it downstream
//   with valid/ready, and returns a flop-driven acknowledge to the source.
//
// Optional feature macro: FPGA_SYNC_HS_PARITY_EN
//   When defined, src_parity / dest_parity_err exist and each captured word
//   carries an even-parity error flag. Handshake timing is identical.
//
// Parameters:
//   DATA_WIDTH   width of the transferred word (default 8)
//   SYNC_STAGES  flops in the src_req synchroniser, 2..4 (default 2)
//
// Ports:
//   dest_clk         in   destination clock
//   dest_resetn      in   asynchronous active-low reset
//   src_req          in   level request from the source domain (async)
//   src_data         in   source data, stable while a request is pending
//   src_parity       in   even parity of src_data (parity build only)
//   dest_ack         out  registered acknowledge to the source domain
//   dest_valid       out  dest_data holds an unconsumed word
//   dest_ready       in   downstream accepts on dest_valid && dest_ready
//   dest_data        out  captured word
//   dest_parity_err  out  parity flag for dest_data (parity build only)

module fpga_sync_handshake_rx #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  dest_clk,
  input  logic                  dest_resetn,
  input  logic                  src_req,
  input  logic [DATA_WIDTH-1:0] src_data,
`ifdef FPGA_SYNC_HS_PARITY_EN
  input  logic                  src_parity,
  output logic                  dest_parity_err,
`endif
  output logic                  dest_ack,
  output logic                  dest_valid,
  input  logic                  dest_ready,
  output logic [DATA_WIDTH-1:0] dest_data
);

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic                   capture;

  // Request synchroniser. Only src_req crosses through flops; src_data is
  // sampled directly because the source holds it until it sees dest_ack.
  always_ff @(posedge dest_clk or negedge dest_resetn) begin
    if (!dest_resetn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], src_req};
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  // State register.
  always_ff @(posedge dest_clk or negedge dest_resetn) begin
    if (!dest_resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A capture needs the output register free or being
  // consumed on this same edge; otherwise the request waits and, because
  // dest_ack stays low, the source stalls.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (req_s && (!dest_valid || dest_ready)) begin
          capture    = 1'b1;
          state_next = ACK;
        end
      end
      ACK: begin
        if (!req_s) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Acknowledge comes straight from a flop so the source's synchroniser
  // never sees a combinational glitch.
  always_ff @(posedge dest_clk or negedge dest_resetn) begin
    if (!dest_resetn) begin
      dest_ack <= 1'b0;
    end else begin
      dest_ack <= (state_next == ACK);
    end
  end

  // Output register. A same-edge capture wins over consumption, so valid
  // stays high and the new word replaces the one being taken.
  always_ff @(posedge dest_clk or negedge dest_resetn) begin
    if (!dest_resetn) begin
      dest_valid <= 1'b0;
      dest_data  <= '0;
    end else begin
      if (capture) begin
        dest_valid <= 1'b1;
        dest_data  <= src_data;
      end else if (dest_valid && dest_ready) begin
        dest_valid <= 1'b0;
      end
    end
  end

`ifdef FPGA_SYNC_HS_PARITY_EN
  // Parity flag travels with the word; flagged words are still delivered.
  always_ff @(posedge dest_clk or negedge dest_resetn) begin
    if (!dest_resetn) begin
      dest_parity_err <= 1'b0;
    end else if (capture) begin
      dest_parity_err <= (^src_data) ^ src_parity;
    end
  end
`endif

endmodule

// File: tb/tb_fpga_sync_handshake_rx.sv
// tb/tb_fpga_sync_handshake_rx.sv - directed self-checking bench for fpga_sync_handshake_rx

module tb_fpga_sync_handshake_rx;

  logic       dest_clk;
  logic       dest_resetn;
  logic       src_req;
  logic [7:0] src_data;
  logic       dest_ready;
  logic       dest_ack;
  logic       dest_valid;
  logic [7:0] dest_data;
  logic       ack3;
  logic       valid3;
  logic [7:0] data3;
`ifdef FPGA_SYNC_HS_PARITY_EN
  logic       src_parity;
  logic       dest_parity_err;
  logic       perr3;
`endif

  int checks = 0;
  int errors = 0;

  fpga_sync_handshake_rx #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .dest_clk        (dest_clk),
    .dest_resetn     (dest_resetn),
    .src_req         (src_req),
    .src_data        (src_data),
`ifdef FPGA_SYNC_HS_PARITY_EN
    .src_parity      (src_parity),
    .dest_parity_err (dest_parity_err),
`endif
    .dest_ack        (dest_ack),
    .dest_valid      (dest_valid),
    .dest_ready      (dest_ready),
    .dest_data       (dest_data)
  );

  fpga_sync_handshake_rx #(.DATA_WIDTH(8), .SYNC_STAGES(3)) dut3 (
    .dest_clk        (dest_clk),
    .dest_resetn     (dest_resetn),
    .src_req         (src_req),
    .src_data        (src_data),
`ifdef FPGA_SYNC_HS_PARITY_EN
    .src_parity      (src_parity),
    .dest_parity_err (perr3),
`endif
    .dest_ack        (ack3),
    .dest_valid      (valid3),
    .dest_ready      (dest_ready),
    .dest_data       (data3)
  );

  initial dest_clk = 1'b0;
  always #5 dest_clk = ~dest_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one active edge and settle just after it.
  task automatic step();
    @(posedge dest_clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    dest_resetn = 1'b0;
    src_req     = 1'b0;
    src_data    = 8'h00;
    dest_ready  = 1'b0;
`ifdef FPGA_SYNC_HS_PARITY_EN
    src_parity  = 1'b0;
`endif
    steps(3);
    check("rst_ack", dest_ack, 1'b0);
    check("rst_valid", dest_valid, 1'b0);
    check("rst_data", dest_data, 8'h00);
`ifdef FPGA_SYNC_HS_PARITY_EN
    check("rst_perr", dest_parity_err, 1'b0);
`endif
    dest_resetn = 1'b1;
    steps(2);

    // Single transfer: capture on edge 3.
    src_data = 8'hA5;
    src_req  = 1'b1;
    step();
    check("s1_e1_valid", dest_valid, 1'b0);
    step();
    check("s1_e2_valid", dest_valid, 1'b0);
    check("s1_e2_ack", dest_ack, 1'b0);
    step();
    check("s1_e3_valid", dest_valid, 1'b1);
    check("s1_e3_ack", dest_ack, 1'b1);
    check("s1_e3_data", dest_data, 8'hA5);
    dest_ready = 1'b1;
    step();
    check("s1_consume_valid", dest_valid, 1'b0);
    check("s1_consume_ack", dest_ack, 1'b1);
    dest_ready = 1'b0;
    src_req    = 1'b0;
    steps(2);
    check("s1_rel_e2_ack", dest_ack, 1'b1);
    step();
    check("s1_rel_e3_ack", dest_ack, 1'b0);
    steps(2);

    // Backpressure: second request stalls while A5 is unconsumed.
    src_data = 8'hA5;
    src_req  = 1'b1;
    steps(3);
    check("s2_first_valid", dest_valid, 1'b1);
    check("s2_first_ack", dest_ack, 1'b1);
    src_req = 1'b0;
    steps(3);
    check("s2_first_rel_ack", dest_ack, 1'b0);
    src_data = 8'h3C;
    src_req  = 1'b1;
    steps(8);
    check("s2_stall_ack", dest_ack, 1'b0);
    check("s2_stall_data", dest_data, 8'hA5);
    check("s2_stall_valid", dest_valid, 1'b1);
    dest_ready = 1'b1;
    step();
    check("s2_swap_data", dest_data, 8'h3C);
    check("s2_swap_valid", dest_valid, 1'b1);
    check("s2_swap_ack", dest_ack, 1'b1);
    dest_ready = 1'b0;
    src_req    = 1'b0;
    steps(3);
    check("s2_rel_ack", dest_ack, 1'b0);
    check("s2_hold_data", dest_data, 8'h3C);

    // Reset mid-handshake.
    dest_ready = 1'b1;
    step();
    check("s3_drain_valid", dest_valid, 1'b0);
    dest_ready = 1'b0;
    src_data   = 8'hC3;
    src_req    = 1'b1;
    steps(3);
    check("s3_pre_ack", dest_ack, 1'b1);
    check("s3_pre_valid", dest_valid, 1'b1);
    check("s3_pre_data", dest_data, 8'hC3);
    dest_resetn = 1'b0;
    src_data    = 8'h5A;
    #1;
    check("s3_async_ack", dest_ack, 1'b0);
    check("s3_async_valid", dest_valid, 1'b0);
    check("s3_async_data", dest_data, 8'h00);
    step();
    dest_resetn = 1'b1;
    steps(2);
    check("s3_post_e2_ack", dest_ack, 1'b0);
    check("s3_post_e2_valid", dest_valid, 1'b0);
    step();
    check("s3_post_e3_ack", dest_ack, 1'b1);
    check("s3_post_e3_valid", dest_valid, 1'b1);
    check("s3_post_e3_data", dest_data, 8'h5A);
    src_req = 1'b0;
    steps(3);
    check("s3_rel_ack", dest_ack, 1'b0);

    // SYNC_STAGES=3 instance: capture on edge 4, release on edge 4.
    dest_resetn = 1'b0;
    step();
    dest_resetn = 1'b1;
    steps(2);
    src_data = 8'hA5;
    src_req  = 1'b1;
    steps(3);
    check("s4_e3_valid3", valid3, 1'b0);
    check("s4_e3_ack3", ack3, 1'b0);
    check("s4_e3_valid2", dest_valid, 1'b1);
    step();
    check("s4_e4_valid3", valid3, 1'b1);
    check("s4_e4_ack3", ack3, 1'b1);
    check("s4_e4_data3", data3, 8'hA5);
    src_req = 1'b0;
    steps(3);
    check("s4_rel_e3_ack3", ack3, 1'b1);
    check("s4_rel_e3_ack2", dest_ack, 1'b0);
    step();
    check("s4_rel_e4_ack3", ack3, 1'b0);

`ifdef FPGA_SYNC_HS_PARITY_EN
    // Parity flag: bad word flagged and held, then a clean word.
    dest_ready = 1'b1;
    step();
    dest_ready = 1'b0;
    src_data   = 8'h01;
    src_parity = 1'b0;
    src_req    = 1'b1;
    steps(3);
    check("p_bad_valid", dest_valid, 1'b1);
    check("p_bad_perr", dest_parity_err, 1'b1);
    src_req = 1'b0;
    steps(5);
    check("p_bad_hold_perr", dest_parity_err, 1'b1);
    check("p_bad_hold_data", dest_data, 8'h01);
    dest_ready = 1'b1;
    step();
    dest_ready = 1'b0;
    src_data   = 8'h03;
    src_parity = 1'b0;
    src_req    = 1'b1;
    steps(3);
    check("p_good_valid", dest_valid, 1'b1);
    check("p_good_perr", dest_parity_err, 1'b0);
    src_req = 1'b0;
    steps(5);
    check("p_good_hold_perr", dest_parity_err, 1'b0);
    check("p_good_hold_data", dest_data, 8'h03);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
